// File: rtl/hazard_sequencer.sv
// Purpose : pipeline hazard unit. It resolves E-stage operand forwarding, load-use
//           stalls, branch/jump redirect flushes and multi-cycle E-stage ops.
// Latency : all control outputs are combinational from state, cnt and the inputs.
//           StallCnt is registered and counts every edge at which StallF is high.
// Backpr. : a multi-cycle op of latency L holds F, D and E for L-1 cycles and
//           bubbles M. A load-use hazard holds F and D, unless a redirect is
//           present, in which case the redirect wins.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   Rs1D, Rs2D                    decode-stage source registers
//   Rs1E, Rs2E, RdE, ResultSrcE   execute-stage sources, destination, result select
//   PCSrcE                        E-stage redirect (taken branch or jump)
//   McStartE, McLatE              multi-cycle op present in E, and its latency L
//   RdM, RdW, RegWriteM/W         M and W destinations and write enables
//   StallF/D/E, FlushD/E/M        pipeline register holds and bubbles
//   ForwardAE, ForwardBE          operand source: 00 regfile, 01 W, 10 M
//   McBusy                        FSM is in MC_BUSY
//   StallCnt                      saturating count of cycles with StallF=1

module hazard_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        McStartE,
    input  logic [3:0]  McLatE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        McBusy,
    output logic [15:0] StallCnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam logic [1:0]  FWD_RF   = 2'b00;
    localparam logic [1:0]  FWD_W    = 2'b01;
    localparam logic [1:0]  FWD_M    = 2'b10;
    localparam logic [1:0]  RES_LOAD = 2'b01;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Unmasked versions of the outputs; the reset mask is applied at the ports.
    logic        lw_stall;
    logic        mc_start;
    logic        mc_hold;
    logic        mc_stall;
    logic        stall_f_raw;
    logic        stall_d_raw;
    logic        stall_e_raw;
    logic        flush_d_raw;
    logic        flush_e_raw;
    logic        flush_m_raw;
    logic [1:0]  fwd_a_raw;
    logic [1:0]  fwd_b_raw;

    // M is newer than W, so it has priority. x0 is never forwarded because it is hardwired.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_raw = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b_raw = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // A load in E whose destination is read by the instruction in D.
    always_comb begin
        lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // A latency-L op stalls in its first E cycle (RUN) and in every MC_BUSY cycle
    // with cnt != 0. Loading L-2 therefore gives L-1 stalled cycles, and the op
    // leaves E in the release cycle (MC_BUSY, cnt == 0). McStartE is not looked at
    // in MC_BUSY, so the op that is still in E during release is not restarted.
    // L of 0 or 1 already completes in a single E cycle.
    always_comb begin
        mc_start = (state_q == RUN) && McStartE && (McLatE >= 4'd2);
        mc_hold  = (state_q == MC_BUSY) && (cnt_q != 4'd0);
        mc_stall = mc_start || mc_hold;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mc_start) begin
                    state_d = MC_BUSY;
                    cnt_d   = McLatE - 4'd2;
                end
            end
            MC_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A multi-cycle stall freezes F/D/E as a unit, so a redirect or a load-use
    // hazard at that moment is simply held and gets re-evaluated on release.
    // Outside MC stalls, a redirect squashes the younger instructions in D and E.
    // It must therefore not hold the PC, even when a load-use hazard is present.
    always_comb begin
        stall_f_raw = 1'b0;
        stall_d_raw = 1'b0;
        stall_e_raw = 1'b0;
        flush_d_raw = 1'b0;
        flush_e_raw = 1'b0;
        flush_m_raw = 1'b0;
        if (mc_stall) begin
            stall_f_raw = 1'b1;
            stall_d_raw = 1'b1;
            stall_e_raw = 1'b1;
            flush_m_raw = 1'b1;
        end else begin
            stall_f_raw = lw_stall && !PCSrcE;
            stall_d_raw = lw_stall && !PCSrcE;
            flush_e_raw = lw_stall || PCSrcE;
            flush_d_raw = PCSrcE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f_raw && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset masks the outputs directly. Forwarding and load-use are driven purely
    // by the inputs, so clearing the flops alone would not silence them.
    always_comb begin
        StallF    = rst && stall_f_raw;
        StallD    = rst && stall_d_raw;
        StallE    = rst && stall_e_raw;
        FlushD    = rst && flush_d_raw;
        FlushE    = rst && flush_e_raw;
        FlushM    = rst && flush_m_raw;
        ForwardAE = rst ? fwd_a_raw : FWD_RF;
        ForwardBE = rst ? fwd_b_raw : FWD_RF;
        McBusy    = rst && (state_q == MC_BUSY);
        StallCnt  = stall_cnt_q;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are clk and rst.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  async active-low reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage sources and destination
- ResultSrcE  in  2  E result select; 2'b01 means load
- PCSrcE  in  1  E-stage redirect (taken branch or jump)
- McStartE  in  1  E holds a multi-cycle op
- McLatE  in  4  latency L of that op, in cycles
- RdM, RdW  in  5  memory and writeback destinations
- RegWriteM, RegWriteW  in  1  memory and writeback write enables
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  bubble the IF/ID, ID/EX and EX/MEM registers
- ForwardAE, ForwardBE  out  2  operand A/B source: 00 register file, 01 W, 10 M
- McBusy  out  1  FSM in MC_BUSY
- StallCnt  out  16  count of cycles with StallF=1

Function
REQ-003 The FSM SHALL have states RUN and MC_BUSY, with a 4-bit down-counter cnt.
REQ-004 Forwarding SHALL be combinational and evaluated per operand.
- ForwardAE = 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
- Otherwise 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
- Otherwise 00.
- ForwardBE uses the same rule with Rs2E.
- M has priority over W.
REQ-005 lwStall SHALL equal (ResultSrcE == 01) AND RdE != 0 AND (RdE == Rs1D OR RdE == Rs2D).
REQ-006 In RUN with McStartE = 1 and L >= 2, the block SHALL, in the same cycle:
- assert StallF, StallD, StallE and FlushM;
- load cnt = L-2;
- go to MC_BUSY.
REQ-007 In RUN with McStartE = 1 and L in {0,1}, there SHALL be no stall and no state change.
REQ-008 In MC_BUSY with cnt != 0, the block SHALL assert StallF, StallD, StallE and FlushM, and decrement cnt.
REQ-009 In MC_BUSY with cnt == 0 (release cycle), the block SHALL:
- deassert all MC stalls;
- return to RUN;
- ignore McStartE, so the same op is not restarted.
REQ-010 The E-stage occupancy of a multi-cycle op SHALL be exactly L cycles, of which L-1 are stalled.
REQ-011 During MC stall cycles, PCSrcE and lwStall SHALL be ignored; FlushD = 0 and FlushE = 0.
REQ-012 Outside MC stall cycles, the block SHALL set:
- StallF = StallD = lwStall AND NOT PCSrcE;
- FlushE = lwStall OR PCSrcE;
- FlushD = PCSrcE;
- StallE = 0 and FlushM = 0.
REQ-013 A simultaneous PCSrcE and lwStall SHALL give the redirect priority: the PC is not held, and both D and E are flushed.
REQ-014 McBusy SHALL be 1 exactly when state == MC_BUSY.
REQ-015 StallCnt SHALL increment on each clk edge where StallF = 1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-016 All outputs except StallCnt SHALL be combinational from state, cnt and the inputs, with no added latency.

Reset
REQ-017 While rst = 0, the block SHALL force state = RUN, cnt = 0 and StallCnt = 0, and SHALL drive all stall, flush, forward and McBusy outputs to 0 regardless of clk.
REQ-018 Reset asserted mid-MC_BUSY SHALL abort the op immediately; after release, operation SHALL resume in RUN.

Verification
REQ-019 Load-use: ResultSrcE = 01, RdE = 5, Rs1D = 5 -> StallF = StallD = FlushE = 1 for one cycle, ForwardAE = 00; with RdE = 0 instead -> no stall.
REQ-020 Forwarding priority: RdM = RdW = 7, both write enables high, Rs1E = 7 -> ForwardAE = 10; drop RegWriteM -> 01; RdW = 0 -> 00.
REQ-021 Multi-cycle op: McStartE held, McLatE = 5 -> StallE = 1 for 4 consecutive cycles, McBusy high for cycles 1-4, release in cycle 4; L = 1 -> no stall; L = 2 -> exactly 1 stall cycle.
REQ-022 Redirect with load-use: PCSrcE = 1 and lwStall = 1 together -> FlushD = FlushE = 1, StallF = 0; the same stimulus during MC_BUSY with cnt = 2 -> only MC stalls, FlushD = 0.
REQ-023 Reset mid-op: rst low at cnt = 3 -> all outputs 0 asynchronously; after release, state RUN and StallCnt = 0.
REQ-024 Counter saturation: preload by 65,540 stall cycles -> StallCnt holds at 16'hFFFF.
